// File: rtl/rally_pkg.sv
// rally_pkg: shared types and constants for the rally engine.
// State encoding, player identifiers and life-counter width.
package rally_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RALLY = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic P_ONE = 1'b0;
  localparam logic P_TWO = 1'b1;

  localparam int LIFE_W = 4;

endpackage

// File: rtl/rally_debounce.sv
// rally_debounce: stability counter on a raw button plus a
// one-cycle swing pulse on each rising edge of the clean level.
module rally_debounce #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic swing
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] UNIT = CW'(1);

  logic [CW-1:0] cnt;
  logic          level;
  logic          prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      prev <= level;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        cnt   <= '0;
        level <= raw;
      end else begin
        cnt <= cnt + UNIT;
      end
    end
  end

  assign swing = level & ~prev;

endmodule

// File: rtl/rally_engine.sv
// rally_engine: ball-and-rally controller for the LED tennis game.
// Tennis (two-ended) or squash (single-ended) play with lives and speed-up.
module rally_engine
  import rally_pkg::*;
#(
  parameter int COURT_LEN    = 16,
  parameter int HIT_WIN      = 2,
  parameter int START_PERIOD = 25_000_000,
  parameter int MIN_PERIOD   = 5_000_000,
  parameter int SPEEDUP      = 2_000_000,
  parameter int LIVES        = 3,
  parameter int DEBOUNCE     = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button_one,
  input  logic                 button_two,
  input  logic                 squash_en,
  output logic [COURT_LEN-1:0] pos,
  output logic                 hittable_one,
  output logic                 hittable_two,
  output logic [LIFE_W-1:0]    lives_one,
  output logic [LIFE_W-1:0]    lives_two,
  output logic                 server,
  output logic [7:0]           rally_count,
  output logic                 game_over,
  output logic                 winner
);

  localparam int IW = $clog2(COURT_LEN);
  localparam int PW = $clog2(START_PERIOD + 1);

  localparam logic [IW-1:0] I_UNIT = IW'(1);
  localparam logic [IW-1:0] I_LAST = IW'(COURT_LEN - 1);
  localparam logic [IW-1:0] WIN_LO = IW'(HIT_WIN);
  localparam logic [IW-1:0] WIN_HI = IW'(COURT_LEN - HIT_WIN);

  localparam logic [PW-1:0] P_UNIT  = PW'(1);
  localparam logic [PW-1:0] P_START = PW'(START_PERIOD);
  localparam logic [PW-1:0] P_MIN   = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] P_STEP  = PW'(SPEEDUP);

  localparam logic [LIFE_W-1:0] L_FULL = LIFE_W'(LIVES);
  localparam logic [LIFE_W-1:0] L_UNIT = LIFE_W'(1);

  state_t state;
  state_t state_d;

  logic [IW-1:0] idx;
  logic [IW-1:0] end_idx;
  logic          dir;
  logic          mode;
  logic          exp_sq;
  logic          lock_one;
  logic          lock_two;
  logic [PW-1:0] period;
  logic [PW-1:0] period_dn;
  logic [PW:0]   period_sub;
  logic [PW-1:0] cnt;

  logic swing_one;
  logic swing_two;
  logic in_rally;
  logic expected;
  logic appr_one;
  logic appr_two;
  logic win_one;
  logic win_two;
  logic hit;
  logic whiff_one;
  logic whiff_two;
  logic due;
  logic at_end;
  logic miss;
  logic wall;
  logic move;
  logic serve;
  logic last_life;

  // Parking cell: squash always serves from index 0.
  function automatic logic [IW-1:0] park(
    input logic sq,
    input logic p
  );
    return (sq || p == P_ONE) ? '0 : I_LAST;
  endfunction

  rally_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb_one (
    .clk  (clk),
    .rst  (rst),
    .raw  (button_one),
    .swing(swing_one)
  );

  rally_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_deb_two (
    .clk  (clk),
    .rst  (rst),
    .raw  (button_two),
    .swing(swing_two)
  );

  // dir = 1 moves toward higher indices (player two's end).
  assign in_rally = (state == RALLY);
  assign expected = mode ? exp_sq : dir;
  assign appr_one = ~dir;
  assign appr_two = mode ? ~dir : dir;
  assign win_one  = (idx < WIN_LO);
  assign win_two  = mode ? (idx < WIN_LO)
                         : (idx >= WIN_HI);

  assign hit = (swing_one & hittable_one)
             | (swing_two & hittable_two);

  assign whiff_one = in_rally & swing_one
                   & (expected == P_ONE)
                   & appr_one & ~hittable_one;
  assign whiff_two = in_rally & swing_two
                   & (expected == P_TWO)
                   & appr_two & ~hittable_two;

  assign due = in_rally && (cnt == period - P_UNIT);

  assign end_idx = (mode || expected == P_ONE)
                 ? '0 : I_LAST;
  assign at_end  = (idx == end_idx)
                && (expected ? appr_two : appr_one);

  assign miss = due & ~hit & at_end;
  assign wall = due & ~hit & ~at_end & mode
              & dir & (idx == I_LAST);
  assign move = due & ~hit & ~at_end & ~wall;

  assign serve = (state == IDLE)
               & (server ? swing_two : swing_one);

  assign last_life = (expected ? lives_two : lives_one)
                  <= L_UNIT;

  // Speed-up clamped at the minimum, no wrap on underflow.
  assign period_sub = {1'b0, period} - {1'b0, P_STEP};
  assign period_dn  = (period_sub[PW] ||
                       period_sub[PW-1:0] < P_MIN)
                    ? P_MIN : period_sub[PW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (serve) state_d = RALLY;
      RALLY:   if (miss)  state_d = last_life ? OVER : IDLE;
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hittable_one = in_rally && expected == P_ONE
                && appr_one && win_one && !lock_one;
    hittable_two = in_rally && expected == P_TWO
                && appr_two && win_two && !lock_two;
    pos = {{(COURT_LEN-1){1'b0}}, 1'b1} << idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      dir         <= 1'b1;
      mode        <= 1'b0;
      exp_sq      <= P_TWO;
      period      <= P_START;
      cnt         <= '0;
      lock_one    <= 1'b0;
      lock_two    <= 1'b0;
      lives_one   <= L_FULL;
      lives_two   <= L_FULL;
      server      <= P_ONE;
      rally_count <= '0;
      game_over   <= 1'b0;
      winner      <= P_ONE;
    end else begin
      if (in_rally) cnt <= due ? '0 : cnt + P_UNIT;
      if (whiff_one) lock_one <= 1'b1;
      if (whiff_two) lock_two <= 1'b1;
      unique case (1'b1)
        serve: begin
          mode        <= squash_en;
          idx         <= park(squash_en, server);
          dir         <= squash_en | (server == P_ONE);
          exp_sq      <= ~server;
          period      <= P_START;
          cnt         <= '0;
          rally_count <= '0;
          lock_one    <= 1'b0;
          lock_two    <= 1'b0;
        end
        hit: begin
          dir      <= ~dir;
          exp_sq   <= ~exp_sq;
          cnt      <= '0;
          period   <= period_dn;
          lock_one <= 1'b0;
          lock_two <= 1'b0;
          if (rally_count != 8'hFF)
            rally_count <= rally_count + 8'd1;
        end
        miss: begin
          server <= expected;
          if (expected == P_ONE)
            lives_one <= lives_one - L_UNIT;
          else
            lives_two <= lives_two - L_UNIT;
          if (last_life) begin
            game_over <= 1'b1;
            winner    <= ~expected;
          end else begin
            idx <= park(mode, expected);
          end
        end
        wall: begin
          dir      <= 1'b0;
          lock_one <= 1'b0;
          lock_two <= 1'b0;
        end
        move: begin
          idx <= dir ? idx + I_UNIT : idx - I_UNIT;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rally_engine.sv
// tb_rally_engine: directed checks of serve, returns, speed-up,
// whiffs, misses, squash wall, coincident hit/step and async reset.
module tb_rally_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_one;
  logic       button_two;
  logic       squash_en;
  logic [7:0] pos;
  logic       hittable_one;
  logic       hittable_two;
  logic [3:0] lives_one;
  logic [3:0] lives_two;
  logic       server;
  logic [7:0] rally_count;
  logic       game_over;
  logic       winner;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rally_engine #(
    .COURT_LEN   (8),
    .HIT_WIN     (2),
    .START_PERIOD(4),
    .MIN_PERIOD  (2),
    .SPEEDUP     (1),
    .LIVES       (2),
    .DEBOUNCE    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .button_one  (button_one),
    .button_two  (button_two),
    .squash_en   (squash_en),
    .pos         (pos),
    .hittable_one(hittable_one),
    .hittable_two(hittable_two),
    .lives_one   (lives_one),
    .lives_two   (lives_two),
    .server      (server),
    .rally_count (rally_count),
    .game_over   (game_over),
    .winner      (winner)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raw press held long enough to debounce; the swing
  // acts on the third rising edge after this call starts.
  task automatic press(input logic one, input logic two);
    button_one = one;
    button_two = two;
    repeat (3) @(negedge clk);
    button_one = 1'b0;
    button_two = 1'b0;
  endtask

  task automatic wait_pos(input logic [7:0] v);
    int n;
    n = 0;
    while (pos != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pos", pos, v);
  endtask

  task automatic spacing(input string tag, input int exp);
    logic [7:0] p0;
    int n;
    p0 = pos;
    n  = 0;
    while (pos == p0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst        = 1'b1;
    button_one = 1'b0;
    button_two = 1'b0;
    squash_en  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_pos",   pos, 8'h01);
    chk("rst_l1",    lives_one, 2);
    chk("rst_l2",    lives_two, 2);
    chk("rst_srv",   server, 0);
    chk("rst_rally", rally_count, 0);
    chk("rst_over",  game_over, 0);
    chk("rst_win",   winner, 0);
    chk("rst_h1",    hittable_one, 0);
    chk("rst_h2",    hittable_two, 0);

    // Tennis serve by player one
    press(1'b1, 1'b0);
    chk("serve_pos", pos, 8'h01);
    spacing("step_a", 4);
    chk("pos_a", pos, 8'h02);
    spacing("step_b", 4);
    chk("pos_b", pos, 8'h04);
    wait_pos(8'h20);
    chk("h2_off_20", hittable_two, 0);
    wait_pos(8'h40);
    chk("h2_on_40", hittable_two, 1);
    chk("h1_off_40", hittable_one, 0);

    // Player two returns at the last cell
    wait_pos(8'h80);
    press(1'b0, 1'b1);
    chk("ret1_pos", pos, 8'h80);
    chk("ret1_rally", rally_count, 1);
    chk("ret1_h2", hittable_two, 0);
    spacing("ret1_step", 3);
    chk("ret1_dir", pos, 8'h40);

    // Player one returns on a due step: hit wins
    wait_pos(8'h01);
    chk("h1_on_01", hittable_one, 1);
    press(1'b1, 1'b0);
    chk("ret2_pos", pos, 8'h01);
    chk("ret2_rally", rally_count, 2);
    spacing("ret2_step_a", 2);
    chk("ret2_pos_a", pos, 8'h02);
    spacing("ret2_step_b", 2);

    // Early swing by player two is a whiff
    wait_pos(8'h08);
    press(1'b0, 1'b1);
    chk("whiff_h2", hittable_two, 0);
    wait_pos(8'h40);
    chk("lock_h2_40", hittable_two, 0);
    n = 0;
    while (lives_two != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("miss1_l2", lives_two, 1);
    chk("miss1_l1", lives_one, 2);
    chk("miss1_srv", server, 1);
    chk("miss1_pos", pos, 8'h80);
    chk("miss1_over", game_over, 0);
    repeat (8) @(negedge clk);
    chk("idle_park", pos, 8'h80);
    press(1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("idle_p1_ign", pos, 8'h80);

    // Player two serves, player one returns, two misses
    press(1'b0, 1'b1);
    chk("serve2_rally", rally_count, 0);
    spacing("serve2_step", 4);
    chk("serve2_pos", pos, 8'h40);
    wait_pos(8'h01);
    press(1'b1, 1'b0);
    chk("ret3_rally", rally_count, 1);
    n = 0;
    while (!game_over && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("over_flag", game_over, 1);
    chk("over_win", winner, 0);
    chk("over_l2", lives_two, 0);
    chk("over_l1", lives_one, 2);
    chk("over_pos", pos, 8'h80);
    press(1'b0, 1'b1);
    repeat (8) @(negedge clk);
    chk("over_hold", pos, 8'h80);
    chk("over_stay", game_over, 1);

    // Squash: wall reflection and shared end
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    squash_en = 1'b1;
    press(1'b1, 1'b0);
    chk("sq_serve", pos, 8'h01);
    wait_pos(8'h80);
    spacing("sq_wall", 8);
    chk("sq_wall_pos", pos, 8'h40);
    wait_pos(8'h02);
    chk("sq_h2_on", hittable_two, 1);
    chk("sq_h1_off", hittable_one, 0);
    press(1'b1, 1'b1);
    chk("sq_ret_pos", pos, 8'h02);
    chk("sq_ret_rally", rally_count, 1);
    spacing("sq_ret_step", 3);
    chk("sq_ret_dir", pos, 8'h04);
    n = 0;
    while (lives_one != 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("sq_miss_l1", lives_one, 1);
    chk("sq_miss_l2", lives_two, 2);
    chk("sq_miss_srv", server, 0);
    chk("sq_miss_pos", pos, 8'h01);

    // Hit coinciding with the due step at the last cell
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    squash_en = 1'b0;
    press(1'b1, 1'b0);
    wait_pos(8'h80);
    @(negedge clk);
    press(1'b0, 1'b1);
    chk("coin_pos", pos, 8'h80);
    chk("coin_rally", rally_count, 1);
    chk("coin_l2", lives_two, 2);
    spacing("coin_step", 3);
    chk("coin_dir", pos, 8'h40);

    // Asynchronous reset mid-rally, before the next edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pos", pos, 8'h01);
    chk("arst_rally", rally_count, 0);
    chk("arst_h1", hittable_one, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_idle", pos, 8'h01);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
